// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, RTS, shift, parity, ACK, timeout)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_frame;
  logic [3:0]    r_bit;
  logic          r_drive;
  logic          r_done;
  logic          r_err;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_prev;

  logic          w_clk_s;
  logic          w_data_s;
  logic          w_fall;
  logic [2:0]    w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [9:0]    w_frame_n;
  logic [3:0]    w_bit_n;
  logic          w_drive_n;
  logic          w_done_n;
  logic          w_err_n;
  logic          w_clk_oe_n;
  logic          w_data_oe_n;

  assign w_clk_s  = r_clk_sync[1];
  assign w_data_s = r_data_sync[1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  // Synchronise both PS/2 lines and keep the previous clock sample for fall detection; idle lines are high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
      r_clk_prev  <= w_clk_s;
    end

  // Next-state logic; one counter serves as inhibit timer and then as RTS-to-ACK timeout
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_frame_n = r_frame;
    w_bit_n   = r_bit;
    w_drive_n = r_drive;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    case (r_state)
      S_IDLE:
        if (tx_valid) begin
          w_state_n = S_INHIBIT;
          w_cnt_n   = '0;
          w_frame_n = {1'b1, ~^tx_data, tx_data};
          w_bit_n   = '0;
          w_drive_n = 1'b0;
        end
      S_INHIBIT:
        if (r_cnt == INH_LAST) begin
          w_state_n = S_RTS;
          w_cnt_n   = '0;
          w_drive_n = 1'b1;
        end else
          w_cnt_n = r_cnt + 1'b1;
      S_RTS, S_SHIFT, S_ACK:
        if (r_cnt == TO_LAST) begin
          w_state_n = S_IDLE;
          w_err_n   = 1'b1;
          w_drive_n = 1'b0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
          if (r_state == S_RTS)
            w_state_n = S_SHIFT;
          else if (w_fall && r_state == S_SHIFT) begin
            w_drive_n = ~r_frame[0];
            w_frame_n = {1'b0, r_frame[9:1]};
            w_bit_n   = r_bit + 4'd1;
            w_state_n = (r_bit == 4'd9) ? S_ACK : S_SHIFT;
          end else if (w_fall) begin
            w_err_n   = w_data_s;
            w_state_n = w_data_s ? S_IDLE : S_RELEASE;
          end
        end
      S_RELEASE:
        if (w_clk_s && w_data_s) begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Line enables are derived from the next state so the open-drain outputs come straight from flops
  always_comb begin
    w_clk_oe_n  = (w_state_n == S_INHIBIT);
    w_data_oe_n = (w_state_n == S_INHIBIT && w_cnt_n == INH_LAST) ||
                  ((w_state_n == S_RTS || w_state_n == S_SHIFT) && w_drive_n);
  end

  // State and output registers; reset releases both lines immediately and drops the byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_bit     <= '0;
      r_drive   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_frame   <= w_frame_n;
      r_bit     <= w_bit_n;
      r_drive   <= w_drive_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      r_clk_oe  <= w_clk_oe_n;
      r_data_oe <= w_data_oe_n;
    end

  assign tx_ready    = (r_state == S_IDLE);
  assign tx_busy     = ~tx_ready;
  assign tx_done     = r_done;
  assign tx_error    = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, tx_busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_pass = 0, n_tot = 0;
  int n_done = 0, n_err = 0, n_clkoe = 0, n_ovl = 0, n_bad = 0;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         f11;
    bit         exp_done;
  } vec_t;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(400)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .tx_busy(tx_busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Count pulses, inhibit cycles and overlap cycles; flag handshake inconsistencies
  always @(negedge clk)
    if (!rst) begin
      if (tx_done) n_done++;
      if (tx_error) n_err++;
      if (ps2_clk_oe) n_clkoe++;
      if (ps2_clk_oe && ps2_data_oe) n_ovl++;
      if ((tx_busy == tx_ready) || (tx_done && tx_error)) n_bad++;
    end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Device: waits for RTS (cycle 0), clocks 10 bits with a 30-cycle period starting at cycle 5,
  // optionally pulls data low for ACK, then issues clock 11 with its fall at cycle f11
  task automatic dev_run(input bit ack, input int f11, output logic [10:0] fr, output bit ok);
    int n;
    ok = 0;
    fr = '0;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) return;
    ok = 1;
    repeat (5) @(negedge clk);
    n = 5;
    fr[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (15) @(negedge clk);
      dev_clk_low = 1'b0;
      fr[i] = ps2_data_in;
      repeat (15) @(negedge clk);
      n += 30;
    end
    if (ack) dev_data_low = 1'b1;
    while (n < f11) begin @(negedge clk); n++; end
    dev_clk_low = 1'b1;
    repeat (15) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit ack, input int f11, input bit exp_done, input string nm);
    int d0, e0, c0, o0, waited;
    logic [10:0] fr;
    bit ok;
    d0 = n_done; e0 = n_err; c0 = n_clkoe; o0 = n_ovl;
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk({nm, "_accept_busy"}, int'(tx_ready), 0);
    waited = 0;
    fork
      dev_run(ack, f11, fr, ok);
      begin
        while (!(tx_done || tx_error) && waited < 1000) begin @(negedge clk); waited++; end
      end
    join
    repeat (5) @(negedge clk);
    chk({nm, "_completes"}, int'(waited < 1000), 1);
    chk({nm, "_rts_seen"}, int'(ok), 1);
    chk({nm, "_frame"}, int'(fr), int'(frame_of(b)));
    chk({nm, "_done_pulses"}, n_done - d0, int'(exp_done));
    chk({nm, "_err_pulses"}, n_err - e0, int'(!exp_done));
    chk({nm, "_inhibit_len"}, n_clkoe - c0, 8);
    chk({nm, "_start_overlap"}, n_ovl - o0, 1);
    chk({nm, "_ready_after"}, int'(tx_ready), 1);
    chk({nm, "_lines_free"}, int'(ps2_clk_oe | ps2_data_oe), 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] b;
    bit a;
    int n, d0, e0, c0, o0;
    logic [10:0] fr1, fr2;
    bit ok1, ok2;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tbl[0] = '{8'hED, 1'b1, 310, 1'b1};
    tbl[1] = '{8'h00, 1'b0, 310, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 310, 1'b1};
    tbl[3] = '{8'h80, 1'b1, 396, 1'b1};
    tbl[4] = '{8'h5A, 1'b1, 397, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 310, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_error", int'(tx_error), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted in the middle of the inhibit phase
    d0 = n_done; e0 = n_err;
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_inhibiting", int'(ps2_clk_oe), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_clk_oe_async", int'(ps2_clk_oe), 0);
    chk("midrst_data_oe_async", int'(ps2_data_oe), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_no_err", n_err - e0, 0);
    chk("midrst_clk_free", int'(ps2_clk_oe), 0);

    for (int i = 0; i < 6; i++)
      send(tbl[i].data, tbl[i].ack, tbl[i].f11, tbl[i].exp_done, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      send(b, a, 310, a, $sformatf("rand%0d_%02h", i, b));
    end

    // Device never clocks: error exactly 400 cycles after RTS entry
    d0 = n_done; e0 = n_err;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    chk("to_rts_entry", int'(ps2_data_oe), 1);
    n = 0;
    while (!tx_error && n < 1000) begin @(negedge clk); n++; end
    chk("to_latency", n, 400);
    chk("to_ready_with_pulse", int'(tx_ready), 1);
    chk("to_clk_oe", int'(ps2_clk_oe), 0);
    chk("to_data_oe", int'(ps2_data_oe), 0);
    repeat (3) @(negedge clk);
    chk("to_err_pulses", n_err - e0, 1);
    chk("to_no_done", n_done - d0, 0);

    // Back-to-back: valid held high with a new byte during the first transfer
    d0 = n_done; e0 = n_err; c0 = n_clkoe; o0 = n_ovl;
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hF4;
    chk("b2b_busy", int'(tx_busy), 1);
    fork
      begin
        dev_run(1'b1, 310, fr1, ok1);
        dev_run(1'b1, 310, fr2, ok2);
      end
      begin
        n = 0;
        while (!tx_done && n < 1000) begin @(negedge clk); n++; end
        chk("b2b_ready_in_done", int'(tx_ready), 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_reaccept_clk_oe", int'(ps2_clk_oe), 1);
        chk("b2b_reaccept_busy", int'(tx_busy), 1);
        n = 0;
        while (!tx_done && n < 1000) begin @(negedge clk); n++; end
      end
    join
    repeat (5) @(negedge clk);
    chk("b2b_rts1", int'(ok1), 1);
    chk("b2b_rts2", int'(ok2), 1);
    chk("b2b_frame1", int'(fr1), int'(frame_of(8'hED)));
    chk("b2b_frame2", int'(fr2), int'(frame_of(8'hF4)));
    chk("b2b_done_pulses", n_done - d0, 2);
    chk("b2b_err_pulses", n_err - e0, 0);
    chk("b2b_inhibit_len", n_clkoe - c0, 16);
    chk("b2b_overlap", n_ovl - o0, 2);

    chk("handshake_consistency", n_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
